// File: rtl/frame_update_sequencer.sv
// Per-frame update scheduler: debounces the direction buttons, then at each frame start runs
// the level and player request/done handshakes in order and divides frames into anim ticks.
module frame_update_sequencer #(
  parameter int VBLANK_LINE   = 515,
  parameter int DEBOUNCE_BITS = 20,
  parameter int ANIM_DIV      = 6,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        level_req,
  input  logic        level_done,
  output logic        player_req,
  input  logic        player_done,
  output logic [3:0]  dir,
  output logic        anim_tick,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        overrun
);

  // state  | meaning
  // IDLE   | waiting for the first blanking line
  // LATCH  | capture filtered direction vector
  // LEVEL  | level_req high, waiting for level_done or timeout
  // PLAYER | player_req high, waiting for player_done or timeout
  // ANIM   | advance the frame divider, issue anim_tick when due
  typedef enum logic [2:0] {IDLE, LATCH, LEVEL, PLAYER, ANIM} state_t;

  localparam logic [9:0]  VB_LINE   = 10'(VBLANK_LINE);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_FULL = '1;

  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q, stable_q;
  logic [3:0] sync1_d, sync2_d, stable_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q [4];
  logic [DEBOUNCE_BITS-1:0] db_cnt_d [4];
  logic [9:0]  prev_v_q, prev_v_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  anim_cnt_q, anim_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  dir_q, dir_d;
  logic        level_req_q, level_req_d;
  logic        player_req_q, player_req_d;
  logic        anim_tick_q, anim_tick_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        frame_start;
  logic [3:0]  dir_filt;
  logic        unused_hcount;

  assign unused_hcount = ^hCount;
  assign frame_start   = (vCount == VB_LINE) && (prev_v_q != VB_LINE);

  // Opposing directions pressed together cancel out.
  assign dir_filt = {stable_q[3] & ~stable_q[2], stable_q[2] & ~stable_q[3],
                     stable_q[1] & ~stable_q[0], stable_q[0] & ~stable_q[1]};

  always_comb begin
    sync1_d  = {btn_up, btn_down, btn_left, btn_right};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_FULL) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_v_d     = vCount;
    timer_d      = timer_q;
    anim_cnt_d   = anim_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    dir_d        = dir_q;
    level_req_d  = 1'b0;
    player_req_d = 1'b0;
    anim_tick_d  = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d     = LATCH;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      LATCH: begin
        dir_d       = dir_filt;
        state_d     = LEVEL;
        level_req_d = 1'b1;
      end
      LEVEL: begin
        if ((level_done && level_req_q) || timer_q == TO_LAST) begin
          if (!(level_done && level_req_q)) overrun_d = 1'b1;
          timer_d      = '0;
          state_d      = PLAYER;
          player_req_d = 1'b1;
        end else begin
          timer_d     = timer_q + 16'd1;
          level_req_d = 1'b1;
        end
      end
      PLAYER: begin
        if ((player_done && player_req_q) || timer_q == TO_LAST) begin
          if (!(player_done && player_req_q)) overrun_d = 1'b1;
          timer_d     = '0;
          state_d     = ANIM;
          anim_tick_d = (anim_cnt_q == ANIM_LAST);
        end else begin
          timer_d      = timer_q + 16'd1;
          player_req_d = 1'b1;
        end
      end
      ANIM: begin
        anim_cnt_d = (anim_cnt_q == ANIM_LAST) ? 8'd0 : anim_cnt_q + 8'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && frame_start) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      prev_v_q     <= '0;
      timer_q      <= '0;
      anim_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      dir_q        <= '0;
      level_req_q  <= 1'b0;
      player_req_q <= 1'b0;
      anim_tick_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      prev_v_q     <= prev_v_d;
      timer_q      <= timer_d;
      anim_cnt_q   <= anim_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      dir_q        <= dir_d;
      level_req_q  <= level_req_d;
      player_req_q <= player_req_d;
      anim_tick_q  <= anim_tick_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign level_req  = level_req_q;
  assign player_req = player_req_q;
  assign dir        = dir_q;
  assign anim_tick  = anim_tick_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench for frame_update_sequencer with short debounce, timeout and anim divider.
module tb_frame_update_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic        level_done = 0, player_done = 0;
  logic        level_req, player_req, anim_tick, busy, overrun;
  logic [3:0]  dir;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_update_sequencer #(
    .VBLANK_LINE(515), .DEBOUNCE_BITS(4), .ANIM_DIV(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .level_req(level_req), .level_done(level_done),
    .player_req(player_req), .player_done(player_done),
    .dir(dir), .anim_tick(anim_tick), .frame_cnt(frame_cnt),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after E0 (state LATCH).
  task automatic start_frame();
    vCount = 10'd0;
    step(1);
    vCount = 10'd515;
    step(1);
    vCount = 10'd516;
  endtask

  // Starts a frame and observes it until busy drops; index 0 is the cycle after E0.
  task automatic run_frame(output int lcnt, output int pcnt, output int bcnt,
                           output int tcnt, output int lfirst, output int pfirst);
    lcnt = 0; pcnt = 0; bcnt = 0; tcnt = 0; lfirst = -1; pfirst = -1;
    start_frame();
    for (int i = 0; i < 80; i++) begin
      if (level_req)  begin lcnt++; if (lfirst < 0) lfirst = i; end
      if (player_req) begin pcnt++; if (pfirst < 0) pfirst = i; end
      if (anim_tick) tcnt++;
      if (busy) bcnt++;
      else break;
      step(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  int lc, pc, bc, tc, lf, pf;
  logic [6:0] tick_mask;
  int waited;

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_level_req", level_req, 0);
    check("rst_player_req", player_req, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_dir", dir, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_anim_tick", anim_tick, 0);

    // Immediate dones: one-cycle requests in order, four busy cycles.
    level_done = 1; player_done = 1;
    run_frame(lc, pc, bc, tc, lf, pf);
    check("f1_lreq_cycles", lc, 1);
    check("f1_preq_cycles", pc, 1);
    check("f1_lreq_first", lf, 1);
    check("f1_preq_first", pf, 2);
    check("f1_busy_cycles", bc, 4);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_overrun", overrun, 0);
    tick_mask = '0;
    tick_mask[0] = (tc != 0);
    for (int f = 1; f < 7; f++) begin
      step(3);
      run_frame(lc, pc, bc, tc, lf, pf);
      tick_mask[f] = (tc == 1);
    end
    check("anim_tick_frames", tick_mask, 7'b0100100);
    check("f7_frame_cnt", frame_cnt, 7);

    // Debounce and direction filter.
    btn_right = 1;
    step(40);
    run_frame(lc, pc, bc, tc, lf, pf);
    check("dir_right", dir, 4'b0001);
    btn_left = 1;
    step(5);
    btn_left = 0;
    step(30);
    run_frame(lc, pc, bc, tc, lf, pf);
    check("dir_left_glitch", dir, 4'b0001);
    btn_up = 1; btn_down = 1;
    step(40);
    run_frame(lc, pc, bc, tc, lf, pf);
    check("dir_up_down_cancel", dir, 4'b0001);
    btn_down = 0;
    step(40);
    run_frame(lc, pc, bc, tc, lf, pf);
    check("dir_up_right", dir, 4'b1001);
    check("pre_timeout_overrun", overrun, 0);

    // Level timeout: request lasts exactly TIMEOUT cycles, player still runs.
    level_done = 0;
    run_frame(lc, pc, bc, tc, lf, pf);
    check("to_lreq_cycles", lc, 16);
    check("to_preq_cycles", pc, 1);
    check("to_busy_cycles", bc, 19);
    check("to_overrun", overrun, 1);

    // Second frame start during LEVEL.
    do_reset();
    check("rst2_overrun", overrun, 0);
    start_frame();
    step(3);
    vCount = 10'd0;
    step(1);
    vCount = 10'd515;
    step(1);
    vCount = 10'd0;
    check("retrig_overrun", overrun, 1);
    check("retrig_frame_cnt", frame_cnt, 1);
    level_done = 1;
    waited = 0;
    while (busy && waited < 40) begin step(1); waited++; end
    check("retrig_completes", busy, 0);
    check("retrig_frame_cnt_end", frame_cnt, 1);

    // Asynchronous reset while player_req is high.
    do_reset();
    player_done = 0;
    step(40);
    start_frame();
    waited = 0;
    while (!player_req && waited < 20) begin step(1); waited++; end
    check("pre_rst_player_req", player_req, 1);
    check("pre_rst_dir", dir, 4'b1001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_player_req", player_req, 0);
    check("async_busy", busy, 0);
    check("async_frame_cnt", frame_cnt, 0);
    check("async_dir", dir, 0);
    step(2);
    rst = 1'b0;
    player_done = 1;
    step(2);
    run_frame(lc, pc, bc, tc, lf, pf);
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_lreq", lc, 1);
    check("post_rst_preq", pc, 1);
    check("post_rst_busy", bc, 4);
    check("post_rst_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
